calc_op_ctrl: RTL and testbench
===============================

# calc_op_ctrl

Operation sequencer for the integer calculator, sitting between the debounced keypad decoder and the display formatter (seg/LCD). It does five things:
- Accumulates decimal digit presses into two signed operands.
- Latches the selected operator.
- On the equals key, runs the arithmetic: one-cycle add/subtract, or a WIDTH-cycle shift-add multiply.
- Presents a signed result with a one-cycle valid strobe.
- Drives the value currently shown on the display.

## Interface
Parameters:
- WIDTH, 14, operand magnitude width in bits; must hold 10^MAX_DIGITS−1.
- MAX_DIGITS, 4, maximum decimal digits per operand.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- key_dig_vld  in  1  single-cycle pulse: digit key pressed.
- key_dig  in  4  digit value 0–9; values 10–15 are ignored.
- key_op_vld  in  1  single-cycle pulse: operator key pressed.
- key_op  in  2  operator: 00 add, 01 sub, 10 mul, 11 reserved (ignored).
- key_neg  in  1  single-cycle pulse: sign toggle of the operand being entered.
- key_equ  in  1  single-cycle pulse: equals.
- key_clr  in  1  single-cycle pulse: clear all.
- busy  out  1  arithmetic in progress; all keys except clr are ignored while high.
- result  out  2*WIDTH  signed two's-complement result.
- result_vld  out  1  one-cycle strobe when result updates.
- disp_mag  out  2*WIDTH  magnitude of the displayed value.
- disp_neg  out  1  sign of the displayed value.
- state_o  out  3  current state encoding, for debug.

## Operation
- States:
  - ENT_A=0: entering operand A.
  - ENT_B=1: entering operand B.
  - ADDSUB=2.
  - MUL=3.
  - SHOW=4: result displayed.
- Key priority when several pulses arrive in the same cycle: clr > equ > op > neg > digit. Only the highest-priority key acts.
- Digit key (ENT_A/ENT_B): mag := mag*10 + key_dig while fewer than MAX_DIGITS digits are entered.
  - Further digits are dropped silently.
  - Leading zeros count as digits.
- key_neg toggles the sign flag of the current operand, in any entry state, before or after digits. A −0 operand computes as 0.
- Operator key:
  - In ENT_A: latch op, go to ENT_B with B cleared (mag 0, sign +, digit count 0).
  - In ENT_B: replace the latched op; B is kept.
  - In SHOW: ignored.
- Equals key:
  - In ENT_A: result := A, then SHOW.
  - In ENT_B, op add/sub: go to ADDSUB. B with no digits entered counts as 0.
  - In ENT_B, op mul: go to MUL.
  - In SHOW: ignored.
- ADDSUB: result := ±A ± B (sign-extended to 2*WIDTH), then SHOW.
- MUL, magnitude shift-add:
  - prod starts at 0.
  - Each cycle i = 0..WIDTH−1: if B[i], prod += A << i.
  - After the last step: result := (signA xor signB) ? −prod : prod. A zero product is forced to sign +.
- SHOW: a digit key clears A and B and restarts ENT_A with that digit as the first digit of A.
- key_clr in any state, including mid-MUL: go to ENT_A, clear A, B and op. result and result_vld do not change.
- Display source:
  - ENT_A shows A.
  - ENT_B shows B (shows 0 until the first B digit).
  - ADDSUB/MUL hold the previous display.
  - SHOW shows result, as magnitude + sign.

## Timing
- Reset state: ENT_A, A=B=0, op=add, busy=0, result=0, result_vld=0, disp_mag=0, disp_neg=0, state_o=0.
- All key inputs are sampled on the rising edge of clk. Operand and display registers update on the same edge, so a digit is visible on disp_mag one cycle after its pulse.
- An equals key sampled at edge k:
  - busy=1 after edge k.
  - ADDSUB: result, result_vld=1 and SHOW all take effect after edge k+1; busy=0 after edge k+1.
  - MUL: multiply steps run on edges k+1..k+WIDTH. result, result_vld=1 and SHOW take effect after edge k+WIDTH+1; busy drops after the same edge.
  - ENT_A equals: result_vld after edge k+1; busy is not asserted.
- result_vld is exactly one cycle wide and low in every other state.
- Keys arriving while busy=1 (except clr) are discarded, not queued.
- Asynchronous rst mid-MUL aborts immediately to reset values, with no result_vld.
- Width rule: the largest magnitude product, (10^MAX_DIGITS−1)^2, must be < 2^(2*WIDTH−1). The defaults satisfy this (99980001 < 2^27).

## Test plan
- Keys 2,3, op add, 4,5,6, equ → result_vld one cycle after the equ edge, result=479, disp_mag=479, disp_neg=0.
- Keys 2,3, op sub, 4,5,6, equ → result=−433 (0xFFFFE4F), disp_mag=433, disp_neg=1.
- Keys 2,3, op mul, 4,5,6, equ → busy high for 15 cycles, result_vld exactly 15 cycles after the equ edge, result=10488.
- Keys 9,9,9,9,9 (5th digit dropped), neg, op mul, 9,9,9,9, equ → result=−99980001. In the same test, keys pressed while busy are ignored.
- Mid-MUL clr → ENT_A, A=0, no result_vld, busy=0 next cycle. Mid-MUL rst → all outputs at reset values.
- Same-cycle equ+digit in ENT_B → only the equ acts. In SHOW, digit 7 → disp_mag=7 and state ENT_A.

Source files
------------

// File: rtl/calc_op_ctrl.sv
// calc_op_ctrl: operation sequencer for the integer calculator.
// Collects decimal digits into two signed operands, latches an operator and on
// equals computes add/sub in one cycle or multiply by WIDTH-step shift-add.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   key_dig_vld/key_dig         digit key pulse and value (10-15 ignored)
//   key_op_vld/key_op           operator key pulse and code (00 add, 01 sub, 10 mul)
//   key_neg, key_equ, key_clr   sign toggle, equals, clear-all pulses
//   busy                        arithmetic in progress
//   result/result_vld           signed result and one-cycle update strobe
//   disp_mag/disp_neg           magnitude and sign of the displayed value
//   state_o                     current state encoding
module calc_op_ctrl #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_dig_vld,
  input  logic [3:0]           key_dig,
  input  logic                 key_op_vld,
  input  logic [1:0]           key_op,
  input  logic                 key_neg,
  input  logic                 key_equ,
  input  logic                 key_clr,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_vld,
  output logic [2*WIDTH-1:0]   disp_mag,
  output logic                 disp_neg,
  output logic [2:0]           state_o
);

  localparam int unsigned RW  = 2 * WIDTH;
  localparam int unsigned DCW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned SCW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    StEntA   = 3'd0,
    StEntB   = 3'd1,
    StAddSub = 3'd2,
    StMul    = 3'd3,
    StShow   = 3'd4
  } state_e;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [DCW-1:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [1:0]       op_q, op_d;
  logic [RW-1:0]    result_q, result_d;
  logic             result_vld_q, result_vld_d;
  logic [RW-1:0]    disp_mag_q, disp_mag_d;
  logic             disp_neg_q, disp_neg_d;
  logic [RW-1:0]    prod_q, prod_d;
  logic [SCW-1:0]   step_q, step_d;
  // Equals in ENT_A: result is published one cycle later without asserting busy.
  logic             pend_q, pend_d;

  logic                 dig_ok;
  logic [RW-1:0]        a_ext, b_ext;
  logic signed [RW-1:0] a_val, b_val;

  function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] mag,
                                                    input logic [3:0]       dig);
    // Digit count is capped, so the truncation never loses bits.
    return mag * WIDTH'(10) + WIDTH'(dig);
  endfunction

  always_comb begin
    dig_ok = key_dig_vld && (key_dig <= 4'd9);
    a_ext  = {{WIDTH{1'b0}}, a_mag_q};
    b_ext  = {{WIDTH{1'b0}}, b_mag_q};
    // Negating a zero magnitude yields zero, so -0 computes as 0.
    a_val  = a_neg_q ? -a_ext : a_ext;
    b_val  = b_neg_q ? -b_ext : b_ext;
  end

  always_comb begin
    state_d      = state_q;
    a_mag_d      = a_mag_q;
    a_neg_d      = a_neg_q;
    a_cnt_d      = a_cnt_q;
    b_mag_d      = b_mag_q;
    b_neg_d      = b_neg_q;
    b_cnt_d      = b_cnt_q;
    op_d         = op_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    disp_mag_d   = disp_mag_q;
    disp_neg_d   = disp_neg_q;
    prod_d       = prod_q;
    step_d       = step_q;
    pend_d       = pend_q;

    if (key_clr) begin
      state_d = StEntA;
      a_mag_d = '0;
      a_neg_d = 1'b0;
      a_cnt_d = '0;
      b_mag_d = '0;
      b_neg_d = 1'b0;
      b_cnt_d = '0;
      op_d    = OpAdd;
      pend_d  = 1'b0;
      prod_d  = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        StEntA, StEntB: begin
          if (pend_q) begin
            result_d     = a_val;
            result_vld_d = 1'b1;
            pend_d       = 1'b0;
            state_d      = StShow;
          end else if (key_equ) begin
            if (state_q == StEntA) begin
              pend_d = 1'b1;
            end else if (op_q == OpMul) begin
              prod_d  = '0;
              step_d  = '0;
              state_d = StMul;
            end else begin
              state_d = StAddSub;
            end
          end else if (key_op_vld) begin
            if (key_op != OpRsv) begin
              op_d = key_op;
              if (state_q == StEntA) begin
                state_d = StEntB;
                b_mag_d = '0;
                b_neg_d = 1'b0;
                b_cnt_d = '0;
              end
            end
          end else if (key_neg) begin
            if (state_q == StEntA) a_neg_d = ~a_neg_q;
            else                   b_neg_d = ~b_neg_q;
          end else if (dig_ok) begin
            if (state_q == StEntA) begin
              if (a_cnt_q < DCW'(MAX_DIGITS)) begin
                a_mag_d = append_digit(a_mag_q, key_dig);
                a_cnt_d = a_cnt_q + DCW'(1);
              end
            end else if (b_cnt_q < DCW'(MAX_DIGITS)) begin
              b_mag_d = append_digit(b_mag_q, key_dig);
              b_cnt_d = b_cnt_q + DCW'(1);
            end
          end
        end
        StAddSub: begin
          result_d     = (op_q == OpSub) ? a_val - b_val : a_val + b_val;
          result_vld_d = 1'b1;
          state_d      = StShow;
        end
        StMul: begin
          if (step_q == SCW'(WIDTH)) begin
            // A zero product keeps sign + regardless of operand signs.
            result_d     = ((a_neg_q ^ b_neg_q) && (prod_q != '0)) ? -prod_q : prod_q;
            result_vld_d = 1'b1;
            state_d      = StShow;
          end else begin
            if (b_mag_q[step_q]) prod_d = prod_q + (a_ext << step_q);
            step_d = step_q + SCW'(1);
          end
        end
        StShow: begin
          // Higher-priority keys present suppress the digit even though they do nothing here.
          if (!key_equ && !key_op_vld && !key_neg && dig_ok) begin
            a_mag_d = WIDTH'(key_dig);
            a_neg_d = 1'b0;
            a_cnt_d = DCW'(1);
            b_mag_d = '0;
            b_neg_d = 1'b0;
            b_cnt_d = '0;
            state_d = StEntA;
          end
        end
        default: state_d = StEntA;
      endcase
    end

    // Display follows the state being entered so it updates on the same edge.
    case (state_d)
      StEntA: begin
        disp_mag_d = {{WIDTH{1'b0}}, a_mag_d};
        disp_neg_d = a_neg_d;
      end
      StEntB: begin
        disp_mag_d = {{WIDTH{1'b0}}, b_mag_d};
        disp_neg_d = b_neg_d;
      end
      StShow: begin
        disp_mag_d = result_d[RW-1] ? -result_d : result_d;
        disp_neg_d = result_d[RW-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEntA;
      a_mag_q      <= '0;
      a_neg_q      <= 1'b0;
      a_cnt_q      <= '0;
      b_mag_q      <= '0;
      b_neg_q      <= 1'b0;
      b_cnt_q      <= '0;
      op_q         <= OpAdd;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      disp_mag_q   <= '0;
      disp_neg_q   <= 1'b0;
      prod_q       <= '0;
      step_q       <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_mag_q      <= a_mag_d;
      a_neg_q      <= a_neg_d;
      a_cnt_q      <= a_cnt_d;
      b_mag_q      <= b_mag_d;
      b_neg_q      <= b_neg_d;
      b_cnt_q      <= b_cnt_d;
      op_q         <= op_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      disp_mag_q   <= disp_mag_d;
      disp_neg_q   <= disp_neg_d;
      prod_q       <= prod_d;
      step_q       <= step_d;
      pend_q       <= pend_d;
    end
  end

  assign busy       = (state_q == StAddSub) || (state_q == StMul);
  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign disp_mag   = disp_mag_q;
  assign disp_neg   = disp_neg_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_calc_op_ctrl.sv
// Self-checking bench for calc_op_ctrl: directed test-plan sequences followed by
// random key traffic, all checked every cycle against an integer reference model.
module tb_calc_op_ctrl;

  localparam int unsigned WIDTH      = 14;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned RW         = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_dig_vld = 1'b0;
  logic [3:0]    key_dig = 4'd0;
  logic          key_op_vld = 1'b0;
  logic [1:0]    key_op = 2'd0;
  logic          key_neg = 1'b0;
  logic          key_equ = 1'b0;
  logic          key_clr = 1'b0;
  logic          busy;
  logic [RW-1:0] result;
  logic          result_vld;
  logic [RW-1:0] disp_mag;
  logic          disp_neg;
  logic [2:0]    state_o;

  int checks   = 0;
  int failures = 0;

  calc_op_ctrl #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_dig_vld (key_dig_vld),
    .key_dig     (key_dig),
    .key_op_vld  (key_op_vld),
    .key_op      (key_op),
    .key_neg     (key_neg),
    .key_equ     (key_equ),
    .key_clr     (key_clr),
    .busy        (busy),
    .result      (result),
    .result_vld  (result_vld),
    .disp_mag    (disp_mag),
    .disp_neg    (disp_neg),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // Reference model: operands as plain integers, result from integer arithmetic,
  // busy phases as a countdown of remaining cycles.
  int     m_state, m_a, m_b, m_ac, m_bc, m_op, m_cnt;
  bit     m_an, m_bn, m_pend, m_vld, m_dneg;
  longint m_res, m_pres, m_dmag;

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_ac = 0; m_bc = 0; m_op = 0; m_cnt = 0;
    m_an = 0; m_bn = 0; m_pend = 0; m_vld = 0; m_dneg = 0;
    m_res = 0; m_pres = 0; m_dmag = 0;
  endtask

  task automatic model_edge(input bit clr, input bit equ, input bit opv, input int op,
                            input bit neg, input bit digv, input int dig);
    longint sa, sb;
    sa = m_an ? -longint'(m_a) : longint'(m_a);
    sb = m_bn ? -longint'(m_b) : longint'(m_b);
    m_vld = 0;
    if (clr) begin
      m_state = 0; m_a = 0; m_b = 0; m_ac = 0; m_bc = 0; m_an = 0; m_bn = 0;
      m_op = 0; m_pend = 0; m_cnt = 0;
    end else if (m_state == 2 || m_state == 3) begin
      m_cnt--;
      if (m_cnt == 0) begin m_res = m_pres; m_vld = 1; m_state = 4; end
    end else if (m_pend) begin
      m_res = sa; m_vld = 1; m_state = 4; m_pend = 0;
    end else if (m_state == 4) begin
      if (!equ && !opv && !neg && digv && dig <= 9) begin
        m_a = dig; m_ac = 1; m_an = 0; m_b = 0; m_bc = 0; m_bn = 0; m_state = 0;
      end
    end else if (equ) begin
      if (m_state == 0) m_pend = 1;
      else begin
        case (m_op)
          0:       m_pres = sa + sb;
          1:       m_pres = sa - sb;
          default: m_pres = sa * sb;
        endcase
        m_cnt   = (m_op == 2) ? WIDTH + 1 : 1;
        m_state = (m_op == 2) ? 3 : 2;
      end
    end else if (opv) begin
      if (op != 3) begin
        m_op = op;
        if (m_state == 0) begin m_state = 1; m_b = 0; m_bc = 0; m_bn = 0; end
      end
    end else if (neg) begin
      if (m_state == 0) m_an = !m_an; else m_bn = !m_bn;
    end else if (digv && dig <= 9) begin
      if (m_state == 0 && m_ac < MAX_DIGITS) begin m_a = m_a * 10 + dig; m_ac++; end
      else if (m_state == 1 && m_bc < MAX_DIGITS) begin m_b = m_b * 10 + dig; m_bc++; end
    end
    if (m_state == 0) begin m_dmag = m_a; m_dneg = m_an; end
    else if (m_state == 1) begin m_dmag = m_b; m_dneg = m_bn; end
    else if (m_state == 4) begin m_dmag = (m_res < 0) ? -m_res : m_res; m_dneg = (m_res < 0); end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [RW-1:0] er;
    er = RW'(m_res);
    chk("state_o", 64'(state_o), 64'(m_state));
    chk("busy", 64'(busy), 64'(m_state == 2 || m_state == 3));
    chk("result_vld", 64'(result_vld), 64'(m_vld));
    chk("result", 64'(result), 64'(er));
    chk("disp_mag", 64'(disp_mag), 64'(m_dmag));
    chk("disp_neg", 64'(disp_neg), 64'(m_dneg));
  endtask

  // One clock of stimulus: drive pulses, let the edge sample them, then check.
  task automatic step(input bit clr, input bit equ, input bit opv, input logic [1:0] op,
                      input bit neg, input bit digv, input logic [3:0] dig);
    key_clr = clr; key_equ = equ; key_op_vld = opv; key_op = op;
    key_neg = neg; key_dig_vld = digv; key_dig = dig;
    @(posedge clk);
    model_edge(clr, equ, opv, int'(op), neg, digv, int'(dig));
    #1;
    key_clr = 0; key_equ = 0; key_op_vld = 0; key_neg = 0; key_dig_vld = 0;
    check_all();
  endtask

  task automatic k_dig(input logic [3:0] d); step(0, 0, 0, 2'd0, 0, 1, d); endtask
  task automatic k_op(input logic [1:0] o);  step(0, 0, 1, o, 0, 0, 4'd0); endtask
  task automatic k_equ();  step(0, 1, 0, 2'd0, 0, 0, 4'd0); endtask
  task automatic k_neg();  step(0, 0, 0, 2'd0, 1, 0, 4'd0); endtask
  task automatic k_clr();  step(1, 0, 0, 2'd0, 0, 0, 4'd0); endtask
  task automatic k_idle(); step(0, 0, 0, 2'd0, 0, 0, 4'd0); endtask

  // Idle until busy drops (bounded); returns how many checked cycles had busy high.
  task automatic drain(output int nb);
    nb = 0;
    for (int i = 0; i < 40 && busy; i++) begin nb++; k_idle(); end
  endtask

  task automatic enter_23_op_456(input logic [1:0] o);
    k_clr(); k_dig(2); k_dig(3); k_op(o); k_dig(4); k_dig(5); k_dig(6);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    int nb;
    logic [RW-1:0] e;
    model_reset();
    #12;
    check_all();
    chk("reset_state", 64'(state_o), 64'd0);
    rst = 1'b0;

    // 23 + 456
    enter_23_op_456(2'b00);
    k_equ();
    drain(nb);
    chk("add_busy_cycles", 64'(nb), 64'd1);
    chk("add_vld", 64'(result_vld), 64'd1);
    chk("add_res", 64'(result), 64'd479);
    chk("add_disp", 64'(disp_mag), 64'd479);
    k_idle();
    chk("vld_one_cycle", 64'(result_vld), 64'd0);

    // 23 - 456
    enter_23_op_456(2'b01);
    k_equ();
    drain(nb);
    e = RW'(-433);
    chk("sub_res", 64'(result), 64'(e));
    chk("sub_disp", 64'(disp_mag), 64'd433);
    chk("sub_neg", 64'(disp_neg), 64'd1);

    // 23 * 456
    enter_23_op_456(2'b10);
    k_equ();
    drain(nb);
    chk("mul_busy_cycles", 64'(nb), 64'd15);
    chk("mul_vld", 64'(result_vld), 64'd1);
    chk("mul_res", 64'(result), 64'd10488);

    // -9999 * 9999 with a dropped fifth digit and keys pressed while busy
    k_clr();
    for (int i = 0; i < 5; i++) k_dig(9);
    chk("digit_cap", 64'(disp_mag), 64'd9999);
    k_neg(); k_op(2'b10);
    for (int i = 0; i < 4; i++) k_dig(9);
    k_equ();
    nb = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      nb++;
      if (i % 3 == 0) k_dig(4'(i % 10)); else if (i % 3 == 1) k_op(2'b00); else k_neg();
    end
    e = RW'(-99980001);
    chk("big_busy_cycles", 64'(nb), 64'd15);
    chk("big_res", 64'(result), 64'(e));
    chk("big_neg", 64'(disp_neg), 64'd1);

    // Clear in the middle of a multiply
    enter_23_op_456(2'b10);
    k_equ();
    repeat (5) k_idle();
    k_clr();
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_state", 64'(state_o), 64'd0);
    chk("clr_keeps_result", 64'(result), 64'(e));
    repeat (15) k_idle();

    // Asynchronous reset in the middle of a multiply
    enter_23_op_456(2'b10);
    k_equ();
    repeat (4) k_idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    repeat (3) k_idle();

    // Same-cycle equals and digit in ENT_B, then a digit in SHOW
    k_dig(1); k_op(2'b00); k_dig(2);
    step(0, 1, 0, 2'd0, 0, 1, 4'd7);
    chk("equ_wins_state", 64'(state_o), 64'd2);
    drain(nb);
    chk("equ_wins_res", 64'(result), 64'd3);
    k_dig(7);
    chk("show_dig_disp", 64'(disp_mag), 64'd7);
    chk("show_dig_state", 64'(state_o), 64'd0);

    // Equals in ENT_A publishes A one cycle later without busy
    k_neg(); k_equ();
    chk("enta_equ_busy", 64'(busy), 64'd0);
    k_idle();
    e = RW'(-7);
    chk("enta_equ_res", 64'(result), 64'(e));

    // Random key traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 7, $urandom_range(0, 99) < 10,
           2'($urandom_range(0, 3)), $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 45,
           4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
